audio_dac: RTL and testbench

//  I2S transmitter: the playback counterpart of the ADC capture path. The Avalon host writes
//  32-bit stereo words (left = [31:16], right = [15:0]) into an internal FIFO. The block

---
 rtl/audio_pkg.sv | 13 +
 rtl/audio_dac_if.sv | 30 +++
 rtl/audio_sync_fifo.sv | 50 +++++
 rtl/audio_dac.sv | 103 ++++++++++
 tb/tb_audio_dac.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/audio_pkg.sv
// Shared definitions for the audio codec interface blocks (DAC playback, ADC capture).
// Word layout is {left, right}, each channel CH_WIDTH bits.
package audio_pkg;
  localparam int DATA_WIDTH = 32;
  localparam int CH_WIDTH   = DATA_WIDTH / 2;
  localparam int FIFO_DEPTH = 256;
  localparam int ADDR_WIDTH = 8;

  localparam int STATE_W = 2;
  localparam logic [STATE_W-1:0] ST_IDLE  = 2'd0;
  localparam logic [STATE_W-1:0] ST_LEFT  = 2'd1;
  localparam logic [STATE_W-1:0] ST_RIGHT = 2'd2;
endpackage

// File: rtl/audio_dac_if.sv
// Host push port plus codec serial pins of the audio DAC.
// Handshake: write is a push strobe, accepted in a cycle only when full is low (ready = !full);
// a write while full is dropped. clear is a one-cycle synchronous flush.
interface audio_dac_if
  import audio_pkg::*;
#(
  parameter int DW = DATA_WIDTH,
  parameter int AW = ADDR_WIDTH
);
  logic          write;
  logic [DW-1:0] writedata;
  logic          full;
  logic          empty;
  logic [AW:0]   used;
  logic          clear;
  logic          underrun;
  logic          bclk;
  logic          daclrc;
  logic          dacdat;

  modport master (
    output write, writedata, clear, bclk, daclrc,
    input  full, empty, used, underrun, dacdat
  );

  modport slave (
    input  write, writedata, clear, bclk, daclrc,
    output full, empty, used, underrun, dacdat
  );
endinterface

// File: rtl/audio_sync_fifo.sv
// Single-clock show-ahead FIFO: rdata always presents the oldest entry while !empty.
// full/empty come from the registered fill level, so they reflect the state before this cycle's pop.
module audio_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             write,
  input  logic [WIDTH-1:0] wdata,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic [AW:0]      used
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (used == (AW+1)'(DEPTH));
  assign empty   = (used == '0);
  assign do_push = write && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      used   <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   used <= used + (AW+1)'(1);
        2'b01:   used <= used - (AW+1)'(1);
        default: used <= used;
      endcase
    end
  end
endmodule

// File: rtl/audio_dac.sv
// I2S transmitter: FIFO-buffered stereo words serialised MSB-first on dacdat,
// timed by bclk/daclrc oversampled in the clk domain.
module audio_dac
  import audio_pkg::*;
#(
  parameter int DW    = DATA_WIDTH,
  parameter int DEPTH = FIFO_DEPTH,
  parameter int AW    = ADDR_WIDTH
) (
  input  logic               clk,
  input  logic               reset,
  audio_dac_if.slave         bus,
  output logic [STATE_W-1:0] dbg_state
);
  localparam int CW    = DW / 2;
  localparam int CNT_W = $clog2(CW + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CW);

  logic [2:0]          bclk_d;
  logic [2:0]          lrc_d;
  logic                fall_evt;
  logic                lrc_s;
  logic                lrc_q;
  logic [STATE_W-1:0]  state;
  logic [DW-1:0]       frame_reg;
  logic [CW-1:0]       shreg;
  logic [CNT_W-1:0]    bit_cnt;
  logic [DW-1:0]       fifo_rdata;
  logic                fifo_empty;
  logic                start_frame;
  logic                to_right;
  logic [DW-1:0]       start_word;

  // Two sync flops then one edge flop; fall_evt is registered, so lrc_d[2] lines up with it.
  always_ff @(posedge clk) begin
    if (reset) begin
      bclk_d   <= '0;
      lrc_d    <= '0;
      fall_evt <= 1'b0;
    end else begin
      bclk_d   <= {bclk_d[1:0], bus.bclk};
      lrc_d    <= {lrc_d[1:0], bus.daclrc};
      fall_evt <= bclk_d[2] & ~bclk_d[1];
    end
  end

  assign lrc_s       = lrc_d[2];
  assign start_frame = fall_evt && lrc_q && !lrc_s && (state != ST_LEFT);
  assign to_right    = fall_evt && !lrc_q && lrc_s && (state == ST_LEFT);
  assign start_word  = fifo_empty ? '0 : fifo_rdata;

  audio_sync_fifo #(.WIDTH(DW), .DEPTH(DEPTH), .AW(AW)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .clear (bus.clear),
    .write (bus.write),
    .wdata (bus.writedata),
    .full  (bus.full),
    .pop   (start_frame),
    .rdata (fifo_rdata),
    .empty (fifo_empty),
    .used  (bus.used)
  );

  assign bus.empty = fifo_empty;
  assign dbg_state = state;

  // A channel switch always emits a 0 first: that is the I2S one-bit delay slot.
  always_ff @(posedge clk) begin
    if (reset || bus.clear) begin
      state        <= ST_IDLE;
      frame_reg    <= '0;
      shreg        <= '0;
      bit_cnt      <= '0;
      lrc_q        <= 1'b0;
      bus.dacdat   <= 1'b0;
      bus.underrun <= 1'b0;
    end else if (fall_evt) begin
      lrc_q <= lrc_s;
      if (start_frame) begin
        frame_reg  <= start_word;
        shreg      <= start_word[DW-1:CW];
        bit_cnt    <= '0;
        bus.dacdat <= 1'b0;
        state      <= ST_LEFT;
        if (fifo_empty) bus.underrun <= 1'b1;
      end else if (to_right) begin
        shreg      <= frame_reg[CW-1:0];
        bit_cnt    <= '0;
        bus.dacdat <= 1'b0;
        state      <= ST_RIGHT;
      end else if (state != ST_IDLE) begin
        if (bit_cnt < CNT_MAX) begin
          bus.dacdat <= shreg[CW-1];
          shreg      <= {shreg[CW-2:0], 1'b0};
          bit_cnt    <= bit_cnt + CNT_W'(1);
        end else begin
          bus.dacdat <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_audio_dac.sv
// Directed bench for audio_dac: drives bclk at clk/8 and daclrc, collects dacdat bits
// per slot and compares against hand-derived words and a write-order scoreboard.
module tb_audio_dac;
  import audio_pkg::*;

  logic       clk;
  logic       reset;
  logic [1:0] dbg_state;
  int         n_vec;
  int         n_miss;
  logic [31:0] exp_q[$];

  audio_dac_if bus ();

  audio_dac dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic write_word(input logic [31:0] d);
    bus.write     = 1'b1;
    bus.writedata = d;
    @(posedge clk); #1;
    bus.write = 1'b0;
    if (exp_q.size() < FIFO_DEPTH) exp_q.push_back(d);
  endtask

  task automatic pulse_clear();
    bus.clear = 1'b1;
    @(posedge clk); #1;
    bus.clear = 1'b0;
    exp_q.delete();
  endtask

  // one bclk period: fall (with new daclrc), sample dacdat 4 clk later, then rise
  task automatic bclk_bit(input logic lrc, output logic b);
    bus.bclk   = 1'b0;
    bus.daclrc = lrc;
    repeat (4) @(posedge clk);
    #1 b = bus.dacdat;
    bus.bclk = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  // fall 0 is the delay bit, falls 1..16 carry the channel, later falls are pad
  task automatic run_slot(input logic lrc, input int nfalls, output logic [15:0] ch,
                          output logic extra);
    logic b;
    ch = '0;
    extra = 1'b0;
    for (int i = 0; i < nfalls; i++) begin
      bclk_bit(lrc, b);
      if (i >= 1 && i <= 16) ch = {ch[14:0], b};
      else extra = extra | b;
    end
  endtask

  initial begin
    logic [15:0] ch_l, ch_r;
    logic        ex_l, ex_r;
    logic [31:0] w;
    n_vec = 0;
    n_miss = 0;
    bus.write = 1'b0;
    bus.writedata = '0;
    bus.clear = 1'b0;
    bus.bclk = 1'b1;
    bus.daclrc = 1'b0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // 1: reset state, idle pins
    repeat (10) @(posedge clk);
    #1;
    check("rst_dacdat", 32'(bus.dacdat), 32'd0);
    check("rst_empty", 32'(bus.empty), 32'd1);
    check("rst_full", 32'(bus.full), 32'd0);
    check("rst_used", 32'(bus.used), 32'd0);
    check("rst_underrun", 32'(bus.underrun), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));

    // 2: single word, 32-bit slots
    write_word(32'hA5A5_3C3C);
    check("t2_used", 32'(bus.used), 32'd1);
    run_slot(1'b1, 4, ch_r, ex_r);
    check("t2_pre_state", 32'(dbg_state), 32'(ST_IDLE));
    run_slot(1'b0, 32, ch_l, ex_l);
    check("t2_left", 32'(ch_l), 32'h0000_A5A5);
    check("t2_left_pad", 32'(ex_l), 32'd0);
    check("t2_used_after", 32'(bus.used), 32'd0);
    run_slot(1'b1, 32, ch_r, ex_r);
    check("t2_right", 32'(ch_r), 32'h0000_3C3C);
    check("t2_right_pad", 32'(ex_r), 32'd0);
    check("t2_underrun", 32'(bus.underrun), 32'd0);
    exp_q.delete();

    // 3: underrun on empty frame start, sticky, cleared by clear
    run_slot(1'b0, 32, ch_l, ex_l);
    check("t3_left", 32'({ch_l, 15'd0, ex_l}), 32'd0);
    check("t3_underrun", 32'(bus.underrun), 32'd1);
    run_slot(1'b1, 8, ch_r, ex_r);
    run_slot(1'b0, 4, ch_l, ex_l);
    check("t3_sticky", 32'(bus.underrun), 32'd1);
    pulse_clear();
    check("t3_clear_underrun", 32'(bus.underrun), 32'd0);
    check("t3_clear_state", 32'(dbg_state), 32'(ST_IDLE));

    // 4: fill to full, drop word 257, play back in order (17-bit slots)
    for (int i = 1; i <= 257; i++) begin
      if (i == 257) begin
        check("t4_full", 32'(bus.full), 32'd1);
        check("t4_used_full", 32'(bus.used), 32'd256);
      end
      write_word({16'(i), 16'(i) ^ 16'hFFFF});
    end
    check("t4_used_drop", 32'(bus.used), 32'd256);
    check("t4_q_size", exp_q.size(), 32'd256);
    run_slot(1'b1, 3, ch_r, ex_r);
    for (int i = 1; i <= 256; i++) begin
      run_slot(1'b0, 17, ch_l, ex_l);
      run_slot(1'b1, 17, ch_r, ex_r);
      w = exp_q.pop_front();
      check($sformatf("t4_word%0d", i), {ch_l, ch_r}, w);
    end
    check("t4_empty", 32'(bus.empty), 32'd1);
    check("t4_underrun", 32'(bus.underrun), 32'd0);

    // 5: clear mid-left aborts the frame
    pulse_clear();
    write_word(32'h1234_5678);
    write_word(32'h9ABC_DEF0);
    run_slot(1'b1, 3, ch_r, ex_r);
    run_slot(1'b0, 5, ch_l, ex_l);
    check("t5_state_left", 32'(dbg_state), 32'(ST_LEFT));
    check("t5_bits", 32'(ch_l), 32'h0000_0001);
    check("t5_dacdat_pre", 32'(bus.dacdat), 32'd1);
    check("t5_used_pre", 32'(bus.used), 32'd1);
    pulse_clear();
    check("t5_dacdat", 32'(bus.dacdat), 32'd0);
    check("t5_used", 32'(bus.used), 32'd0);
    check("t5_state_idle", 32'(dbg_state), 32'(ST_IDLE));
    run_slot(1'b0, 10, ch_l, ex_l);
    check("t5_still_idle", 32'(dbg_state), 32'(ST_IDLE));
    check("t5_quiet", 32'({ch_l, 15'd0, ex_l}), 32'd0);
    run_slot(1'b1, 3, ch_r, ex_r);
    run_slot(1'b0, 2, ch_l, ex_l);
    check("t5_restart", 32'(dbg_state), 32'(ST_LEFT));
    check("t5_underrun", 32'(bus.underrun), 32'd1);

    // 6: push and pop in the same cycle, then reset mid-right
    pulse_clear();
    write_word(32'hC0DE_F00F);
    write_word(32'h0000_0002);
    write_word(32'h0000_0003);
    write_word(32'h0000_0004);
    write_word(32'h0000_0005);
    check("t6_used5", 32'(bus.used), 32'd5);
    run_slot(1'b1, 3, ch_r, ex_r);
    bus.bclk   = 1'b0;
    bus.daclrc = 1'b0;
    repeat (3) @(posedge clk);
    #1 bus.write = 1'b1;
    bus.writedata = 32'h0000_0006;
    @(posedge clk);
    #1 bus.write = 1'b0;
    check("t6_used_same", 32'(bus.used), 32'd5);
    check("t6_delay_bit", 32'(bus.dacdat), 32'd0);
    check("t6_state", 32'(dbg_state), 32'(ST_LEFT));
    bus.bclk = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    ch_l = '0;
    for (int i = 0; i < 16; i++) begin
      logic b;
      bclk_bit(1'b0, b);
      ch_l = {ch_l[14:0], b};
    end
    check("t6_left", 32'(ch_l), 32'h0000_C0DE);
    run_slot(1'b1, 5, ch_r, ex_r);
    check("t6_right_state", 32'(dbg_state), 32'(ST_RIGHT));
    check("t6_right_bits", 32'(ch_r), 32'h0000_000F);
    check("t6_dacdat_pre", 32'(bus.dacdat), 32'd1);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    exp_q.delete();
    check("t6_rst_dacdat", 32'(bus.dacdat), 32'd0);
    check("t6_rst_used", 32'(bus.used), 32'd0);
    check("t6_rst_empty", 32'(bus.empty), 32'd1);
    check("t6_rst_full", 32'(bus.full), 32'd0);
    check("t6_rst_underrun", 32'(bus.underrun), 32'd0);
    check("t6_rst_state", 32'(dbg_state), 32'(ST_IDLE));

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
